// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester-side command/response bundle for both arbiter ports
interface ram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16
);
  logic                  req0, req1;
  logic                  we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy
  );
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin two-port sequencer driving the shared RAM pins and data bus
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_port_arbiter_if.slave     bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
);
  localparam logic [1:0] IDLE = 2'd0, WR = 2'd1, RD = 2'd2, RD_CAP = 2'd3;
  logic [1:0]            state_q, state_d;
  logic                  last_q, last_d, port_q, port_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic                  idle, pick1, acc, sel_we, cap;
  // arbitration, accept decode and next-state; grants are held off while reset is asserted
  always_comb begin
    idle      = state_q == IDLE;
    pick1     = bus.req1 & (~bus.req0 | ~last_q);
    bus.gnt1  = rst_n & idle & pick1;
    bus.gnt0  = rst_n & idle & bus.req0 & ~pick1;
    acc       = bus.gnt0 | bus.gnt1;
    sel_we    = bus.gnt1 ? bus.we1 : bus.we0;
    cap       = state_q == RD_CAP;
    state_d   = acc ? (sel_we ? WR : RD) : (state_q == RD ? RD_CAP : IDLE);
    last_d    = acc ? bus.gnt1 : last_q;
    port_d    = acc ? bus.gnt1 : port_q;
    addr_d    = acc ? (bus.gnt1 ? bus.addr1 : bus.addr0) : addr_q;
    wdata_d   = acc ? (bus.gnt1 ? bus.wdata1 : bus.wdata0) : wdata_q;
    rdata_d   = cap ? ram_data : rdata_q;
    rvalid0_d = cap & ~port_q;
    rvalid1_d = cap & port_q;
  end
  // state and datapath registers; an in-flight read is dropped on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      port_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      port_q    <= port_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end
  assign ram_addr    = addr_q;
  assign ram_cs      = ~idle;
  assign ram_we      = state_q == WR;
  assign ram_oe      = state_q[1];
  assign ram_data    = state_q == WR ? wdata_q : 'z;
  assign bus.rdata   = rdata_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.busy    = ~idle;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized scoreboard bench with a behavioural RAM and transaction-level reference model
module tb_ram_port_arbiter;
  logic        clk = 0;
  logic        rst_n = 0;
  wire  [15:0] ram_data;
  logic [13:0] ram_addr;
  logic        ram_cs, ram_we, ram_oe;
  ram_port_arbiter_if #(.ADDR_WIDTH(14), .DATA_WIDTH(16)) bus ();
  ram_port_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
  );
  always #5 clk = ~clk;

  logic [15:0] mem [0:16383];
  logic [15:0] dout;
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
    if (ram_cs && ram_oe && !ram_we) dout <= mem[ram_addr];
  end
  assign ram_data = (ram_cs && ram_oe && !ram_we) ? dout : 'z;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endfunction

  typedef struct {bit p; logic [15:0] d; int c;} rd_t;
  rd_t         q[$];
  logic [15:0] ref_mem [0:16383];
  bit          last_m = 1;
  int          free_c = 0, wr_c = -1;
  logic [13:0] cur_a;
  logic [15:0] wr_d, rdata_m = 0;
  bit          busy_e, e0, e1, ew;
  logic [13:0] ea;
  logic [15:0] ed;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt", {bus.gnt0, bus.gnt1}, 0);
      chk("rst_rvalid", {bus.rvalid0, bus.rvalid1}, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ctrl", {ram_cs, ram_we, ram_oe}, 0);
      chk("rst_addr", ram_addr, 0);
      checks++;
      if (ram_data !== 16'hzzzz) begin
        failures++;
        $display("FAIL rst_bus_z actual=%h required=zzzz", ram_data);
      end
      last_m = 1; free_c = 0; wr_c = -1; rdata_m = 0;
      q.delete();
    end else begin
      busy_e = cyc < free_c;
      chk("busy", bus.busy, busy_e);
      if (!busy_e) begin
        chk("idle_ctrl", {ram_cs, ram_we, ram_oe}, 0);
        checks++;
        if (ram_data !== 16'hzzzz) begin
          failures++;
          $display("FAIL idle_bus_z actual=%h required=zzzz", ram_data);
        end
      end else if (cyc == wr_c) begin
        chk("wr_ctrl", {ram_cs, ram_we, ram_oe}, 3'b110);
        chk("wr_addr", ram_addr, cur_a);
        chk("wr_data", ram_data, wr_d);
      end else begin
        chk("rd_ctrl", {ram_cs, ram_we, ram_oe}, 3'b101);
        chk("rd_addr", ram_addr, cur_a);
      end
      e1 = !busy_e && bus.req1 && (!bus.req0 || !last_m);
      e0 = !busy_e && bus.req0 && !e1;
      chk("gnt", {bus.gnt0, bus.gnt1}, {e0, e1});
      if (q.size() > 0 && q[0].c == cyc) begin
        chk("rvalid", {bus.rvalid0, bus.rvalid1}, q[0].p ? 2'b01 : 2'b10);
        rdata_m = q[0].d;
        void'(q.pop_front());
      end else chk("rvalid_idle", {bus.rvalid0, bus.rvalid1}, 0);
      chk("rdata", bus.rdata, rdata_m);
      if (e0 || e1) begin
        ew = e1 ? bus.we1 : bus.we0;
        ea = e1 ? bus.addr1 : bus.addr0;
        ed = e1 ? bus.wdata1 : bus.wdata0;
        cur_a = ea;
        last_m = e1;
        if (ew) begin
          ref_mem[ea] = ed;
          wr_d = ed; wr_c = cyc + 1; free_c = cyc + 2;
        end else begin
          q.push_back('{p: e1, d: ref_mem[ea], c: cyc + 3});
          free_c = cyc + 3;
        end
      end
    end
  end

  task automatic op(input bit p, input bit w, input logic [13:0] a, input logic [15:0] d, input bit rst_mid = 0);
    bit got = 0;
    if (p) begin bus.req1 = 1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; end
    else   begin bus.req0 = 1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = p ? bus.gnt1 : bus.gnt0;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL grant_timeout port=%0d actual=none required=grant", p);
    end
    @(posedge clk); #1;
    if (p) bus.req1 = 0; else bus.req0 = 0;
    if (rst_mid) begin
      @(posedge clk); #2 rst_n = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
    end
  endtask

  task automatic rand_ops(input bit p, input int n);
    logic [13:0] b [8];
    b = '{14'h0000, 14'h0FFF, 14'h1000, 14'h1FFF, 14'h2000, 14'h2FFF, 14'h3000, 14'h3FFF};
    for (int i = 0; i < n; i++) begin
      op(p, 1'($urandom), $urandom_range(0, 1) ? b[$urandom_range(0, 7)] : 14'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16384; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    {bus.we0, bus.we1, bus.addr0, bus.addr1, bus.wdata0, bus.wdata1} = 0;
    bus.req0 = 1; bus.req1 = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    fork
      op(0, 0, 14'h0100, 0);
      op(1, 0, 14'h0200, 0);
    join
    op(0, 1, 14'h0FFC, 16'h1234);
    op(0, 0, 14'h0FFC, 0);
    fork
      repeat (4) op(0, 0, 14'h0FFC, 0);
      repeat (4) op(1, 0, 14'h0100, 0);
    join
    op(1, 1, 14'h1FFF, 16'hAAAA);
    op(1, 1, 14'h2000, 16'h5555);
    op(1, 1, 14'h3FFF, 16'hBEEF);
    op(1, 1, 14'h0000, 16'h0001);
    op(0, 0, 14'h1FFF, 0);
    op(0, 0, 14'h2000, 0);
    op(0, 0, 14'h3FFF, 0);
    op(0, 0, 14'h0000, 0);
    op(0, 0, 14'h1FFF, 0, 1);
    op(0, 0, 14'h1FFF, 0);
    op(1, 0, 14'h0010, 0);
    fork
      op(0, 1, 14'h3000, 16'hCAFE);
      op(1, 0, 14'h3000, 0);
    join
    fork
      rand_ops(0, 30);
      rand_ops(1, 30);
    join
    repeat (10) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
